// File: rtl/fib_sequencer_if.sv
// ============================================================================
// Module   : fib_sequencer_if
// Purpose  : Host handshake plus leaf-accumulator strobes for fib_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fib_sequencer_if;
   logic       start;
   logic [3:0] n_in;
   logic [4:0] acc_val;
   logic       acc_inc;
   logic       acc_clr;
   logic       busy;
   logic       done;
   logic       err;
   logic [4:0] result;

   // master: host plus accumulator side; slave: the sequencer itself
   modport master (
      output start, n_in, acc_val,
      input  acc_inc, acc_clr, busy, done, err, result
   );

   modport slave (
      input  start, n_in, acc_val,
      output acc_inc, acc_clr, busy, done, err, result
   );
endinterface

`default_nettype wire

// File: rtl/fib_sequencer.sv
// ============================================================================
// Module   : fib_sequencer
// Purpose  : Stack-based recursive Fibonacci control FSM driving a leaf counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fib_sequencer #(
   parameter int DEPTH = 8,
   parameter int NMAX  = 7
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   fib_sequencer_if.slave   bus
);

   localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             SPW       = $clog2(DEPTH + 1);
   localparam logic [SPW-1:0] c_sp_full = SPW'(DEPTH);
   localparam logic [3:0]     c_nmax    = 4'(NMAX);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_POP   = 3'd2,
      S_EVAL  = 3'd3,
      S_PUSH2 = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [SPW-1:0] r_sp, w_sp_nxt, w_top_idx;
   logic [2:0]     r_x, w_x_nxt;
   logic [2:0]     r_n, w_n_nxt;
   logic [2:0]     r_stack [DEPTH];
   logic           r_err, w_err_nxt;
   logic [4:0]     r_result, w_result_nxt;
   logic           w_push;
   logic [AW-1:0]  w_push_addr;
   logic [2:0]     w_push_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sp     <= '0;
         r_x      <= '0;
         r_n      <= '0;
         r_err    <= 1'b0;
         r_result <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_stack[i] <= '0;
         end
      end else begin
         r_state  <= w_state_nxt;
         r_sp     <= w_sp_nxt;
         r_x      <= w_x_nxt;
         r_n      <= w_n_nxt;
         r_err    <= w_err_nxt;
         r_result <= w_result_nxt;
         if (w_push) begin
            r_stack[w_push_addr] <= w_push_data;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sp_nxt     = r_sp;
      w_x_nxt      = r_x;
      w_n_nxt      = r_n;
      w_err_nxt    = 1'b0;
      w_result_nxt = r_result;
      w_push       = 1'b0;
      w_push_addr  = r_sp[AW-1:0];
      w_push_data  = '0;
      w_top_idx    = r_sp - 1'b1;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.n_in > c_nmax) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_n_nxt     = bus.n_in[2:0];
                  w_state_nxt = S_CLR;
               end
            end
         end
         S_CLR: begin
            w_push      = 1'b1;
            w_push_addr = '0;
            w_push_data = r_n;
            w_sp_nxt    = SPW'(1);
            w_state_nxt = S_POP;
         end
         S_POP: begin
            if (r_sp == '0) begin
               w_state_nxt = S_DONE;
            end else begin
               w_x_nxt     = r_stack[w_top_idx[AW-1:0]];
               w_sp_nxt    = w_top_idx;
               w_state_nxt = S_EVAL;
            end
         end
         S_EVAL: begin
            if (r_x < 3'd2) begin
               w_state_nxt = S_POP;
            end else if (r_sp == c_sp_full) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_push      = 1'b1;
               w_push_data = r_x - 3'd1;
               w_sp_nxt    = r_sp + 1'b1;
               w_state_nxt = S_PUSH2;
            end
         end
         S_PUSH2: begin
            // x-2 lands on top, so that subtree is expanded first
            if (r_sp == c_sp_full) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_push      = 1'b1;
               w_push_data = r_x - 3'd2;
               w_sp_nxt    = r_sp + 1'b1;
               w_state_nxt = S_POP;
            end
         end
         S_DONE: begin
            w_result_nxt = bus.acc_val;
            w_state_nxt  = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Strobes depend only on registered state so the accumulator never sees input glitches
   assign bus.acc_clr = (r_state == S_CLR);
   assign bus.acc_inc = (r_state == S_EVAL) && (r_x < 3'd2);
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.done    = (r_state == S_DONE);
   assign bus.err     = r_err;
   assign bus.result  = r_result;

endmodule

`default_nettype wire

// File: tb/tb_fib_sequencer.sv
// ============================================================================
// Module   : tb_fib_sequencer
// Purpose  : Self-checking bench for fib_sequencer with a leaf-accumulator model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fib_sequencer;

   typedef struct {
      logic [3:0] n;
      int         res;
      int         lat;
   } vec_t;

   typedef struct {
      int res;
      int lat;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [4:0] acc;
   int         checks;
   int         errors;
   int         cyc;
   int         inc_cnt;
   int         clr_cnt;
   int         tot_inc;
   int         tot_clr;
   int         pend_res;
   bit         res_pending;
   exp_t       sb[$];
   exp_t       e_mon;
   vec_t       vecs[8];

   fib_sequencer_if bus ();

   fib_sequencer #(.DEPTH(8), .NMAX(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            acc <= '0;
      else if (bus.acc_clr)  acc <= '0;
      else if (bus.acc_inc)  acc <= acc + 5'd1;
   end
   assign bus.acc_val = acc;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Scoreboard monitor: latency, leaf count and clear count per run
   always @(negedge clk) begin
      if (!rst_n) begin
         res_pending = 1'b0;
      end else begin
         if (res_pending) begin
            res_pending = 1'b0;
            check("result", int'(bus.result), pend_res);
         end
         cyc++;
         if (bus.acc_inc) begin inc_cnt++; tot_inc++; end
         if (bus.acc_clr) begin clr_cnt++; tot_clr++; end
         if (bus.acc_inc || bus.acc_clr) begin
            check("strobe_exclusive", int'(bus.acc_inc && bus.acc_clr), 0);
            check("strobe_not_idle", int'(bus.busy), 1);
         end
         if (bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e_mon = sb.pop_front();
               check("done_latency", cyc, e_mon.lat);
               check("inc_pulses", inc_cnt, e_mon.res);
               check("clr_pulses", clr_cnt, 1);
               pend_res    = e_mon.res;
               res_pending = 1'b1;
            end
         end
         if (!bus.busy && bus.start && bus.n_in <= 4'd7) begin
            cyc     = 0;
            inc_cnt = 0;
            clr_cnt = 0;
         end
      end
   end

   task automatic launch(input logic [3:0] n, input int res, input int lat);
      exp_t e;
      e.res = res;
      e.lat = lat;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.n_in  = n;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; cyc = 0; inc_cnt = 0; clr_cnt = 0;
      tot_inc = 0; tot_clr = 0; pend_res = 0; res_pending = 1'b0;
      vecs[0] = '{4'd0, 1, 5};    vecs[1] = '{4'd1, 1, 5};
      vecs[2] = '{4'd2, 2, 10};   vecs[3] = '{4'd3, 3, 15};
      vecs[4] = '{4'd4, 5, 25};   vecs[5] = '{4'd5, 8, 40};
      vecs[6] = '{4'd6, 13, 65};  vecs[7] = '{4'd7, 21, 105};

      rst_n = 1'b0; bus.start = 1'b0; bus.n_in = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", int'({bus.acc_inc, bus.acc_clr, bus.busy, bus.done,
                                   bus.err, bus.result}), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_strobes", tot_inc + tot_clr, 0);
      check("idle_busy", int'(bus.busy), 0);

      for (int i = 0; i < 8; i++) begin
         launch(vecs[i].n, vecs[i].res, vecs[i].lat);
         wait_done(200, "sweep");
         @(negedge clk);
      end

      // Rejected indices: err one cycle after, never busy, result kept at fib(7)
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b1;
         bus.n_in  = (k == 0) ? 4'd8 : 4'd15;
         @(posedge clk); #1;
         bus.start = 1'b0;
         @(negedge clk);
         check("illegal_err", int'(bus.err), 1);
         check("illegal_busy", int'(bus.busy), 0);
         @(negedge clk);
         check("illegal_err_pulse", int'(bus.err), 0);
         check("illegal_result", int'(bus.result), 21);
      end

      // Start while busy is ignored; a held start is accepted right after done
      launch(4'd5, 8, 40);
      repeat (9) @(posedge clk);
      #1 bus.start = 1'b1; bus.n_in = 4'd2;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (15) @(posedge clk);
      #1 bus.start = 1'b1; bus.n_in = 4'd2;
      begin
         exp_t e2;
         e2.res = 3; e2.lat = 10;
         e2.res = 2;
         sb.push_back(e2);
      end
      wait_done(100, "busy_run");
      @(negedge clk);
      check("gap_idle", int'(bus.busy), 0);
      @(negedge clk);
      check("b2b_clr", int'(bus.acc_clr), 1);
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done(50, "b2b_run");
      @(negedge clk);

      // Asynchronous reset mid-run: no done, then a fresh run works
      launch(4'd7, 21, 105);
      repeat (49) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrun_reset_outputs", int'({bus.acc_inc, bus.acc_clr, bus.busy,
                                          bus.done, bus.err, bus.result}), 0);
      sb.delete();
      repeat (2) @(negedge clk);
      check("reset_no_done", int'(bus.done), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      launch(4'd3, 3, 15);
      wait_done(50, "post_reset_run");
      @(negedge clk);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
